// File: rtl/sram_2p_port_ctrl.sv
// Requester-side controller for a 2-port (1W/1R) SRAM macro: zero-init sweep,
// valid/ready request handling, write-first collision bypass and a 2-entry response FIFO.
module sram_2p_port_ctrl #(
  parameter int BITS   = 2,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [BITS-1:0]   w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [BITS-1:0]   resp_data,
  output logic              init_done,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_aa,
  output logic [BITS-1:0]   sram_d,
  output logic              sram_reb,
  output logic [ADDR_W-1:0] sram_ab,
  input  logic [BITS-1:0]   sram_q
);

  typedef enum logic {INIT, IDLE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_byp_q, s1_byp_d;
  logic [BITS-1:0]   s1_bdata_q, s1_bdata_d;
  logic [BITS-1:0]   fifo_q [2];
  logic [BITS-1:0]   fifo_d [2];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        count_q, count_d;

  logic              w_fire, r_fire, push, pop;
  logic [2:0]        occ;
  logic [BITS-1:0]   push_data;

  assign resp_valid = (count_q != 2'd0);
  assign resp_data  = fifo_q[rptr_q];
  assign pop        = resp_valid & resp_ready;
  // Credit: the response in flight plus buffered entries, minus the one leaving now.
  assign occ        = {2'b00, s1_valid_q} + {1'b0, count_q} - {2'b00, pop};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_ready   = 1'b0;
    r_ready   = 1'b0;
    init_done = 1'b0;
    sram_web  = 1'b1;
    sram_aa   = '0;
    sram_d    = '0;
    sram_reb  = 1'b1;
    sram_ab   = '0;

    case (state_q)
      INIT: begin
        sram_web = 1'b0;
        sram_aa  = cnt_q;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        init_done = 1'b1;
        w_ready   = 1'b1;
        r_ready   = (occ < 3'd2);
      end
      default: state_d = INIT;
    endcase

    // Keep the macro quiet while reset is held, even though the FSM sits in INIT.
    if (reset) begin
      sram_web = 1'b1;
      sram_aa  = '0;
      w_ready  = 1'b0;
      r_ready  = 1'b0;
    end

    w_fire = w_valid & w_ready;
    r_fire = r_valid & r_ready;

    if (w_fire) begin
      sram_web = 1'b0;
      sram_aa  = w_addr;
      sram_d   = w_data;
    end
    if (r_fire) begin
      sram_reb = 1'b0;
      sram_ab  = r_addr;
    end

    // Macro reads old data on a same-address collision; capture the new word instead.
    s1_valid_d = r_fire;
    s1_byp_d   = r_fire & w_fire & (r_addr == w_addr);
    s1_bdata_d = w_data;

    push      = s1_valid_q;
    push_data = s1_byp_q ? s1_bdata_q : sram_q;

    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = push_data;
    wptr_d  = wptr_q ^ push;
    rptr_d  = rptr_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_bdata_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_byp_q   <= s1_byp_d;
      s1_bdata_q <= s1_bdata_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(s1_valid_q && (count_q == 2'd2) && !pop));

endmodule

// File: doc/sram_2p_port_ctrl.md
# sram_2p_port_ctrl

Single-clock requester-side controller for the 2-bit × 512-word two-port SRAM macro (one write port, one read port). It zero-initialises the array after reset and turns valid/ready write and read requests into macro WEB/AA/D and REB/AB strobes. It captures the macro's 1-cycle registered read data, which is garbage whenever REB was high, and resolves same-cycle read/write address collisions as write-first. Responses go into a 2-entry response buffer with valid/ready back-pressure. It sits between the predictor/metadata logic and the macro instance inside the SRAM wrapper.

## Interface
- BITS, 2, data width
- DEPTH, 512, word count
- ADDR_W, 9, address width, log2(DEPTH)

- clock  in  1  single clock; both macro clocks are tied to it
- reset  in  1  asynchronous, active-high
- w_valid  in  1  write request
- w_ready  out  1  write can be accepted
- w_addr  in  ADDR_W  write address
- w_data  in  BITS  write data
- r_valid  in  1  read request
- r_ready  out  1  read can be accepted
- r_addr  in  ADDR_W  read address
- resp_valid  out  1  read response available
- resp_ready  in  1  response consumed
- resp_data  out  BITS  read response data
- init_done  out  1  zero-init sweep complete
- sram_web  out  1  macro write enable, active-low
- sram_aa  out  ADDR_W  macro write address
- sram_d  out  BITS  macro write data
- sram_reb  out  1  macro read enable, active-low
- sram_ab  out  ADDR_W  macro read address
- sram_q  in  BITS  macro read data, registered, valid one cycle after REB=0

## Operation
- States: INIT, IDLE. Reset enters INIT with init counter = 0.
- INIT behaviour:
  - sram_web=0, sram_aa=counter, sram_d=0, sram_reb=1.
  - w_ready=0, r_ready=0, init_done=0.
  - Counter increments each cycle.
  - The cycle in which counter = DEPTH-1 performs the last write; the FSM moves to IDLE on the next edge.
- IDLE behaviour:
  - init_done=1, w_ready=1.
  - Write fire (w_valid & w_ready): sram_web=0, sram_aa=w_addr, sram_d=w_data, combinational pass-through.
  - When no write fires: sram_web=1, sram_aa=0, sram_d=0.
- Read issue (IDLE only):
  - r_ready = (s1_valid + count − pop) < 2, where count is buffer occupancy and pop = resp_valid & resp_ready. r_ready is combinational from resp_ready.
  - On read fire: sram_reb=0, sram_ab=r_addr.
  - When no read fires: sram_reb=1, sram_ab=0.
  - Read fire sets stage register s1_valid. Otherwise s1_valid clears.
- Collision: a read fire and a write fire in the same cycle with r_addr == w_addr set s1_byp=1 and s1_bdata=w_data. This is write-first; the macro itself returns the old value.
- Stage 1: when s1_valid=1, push (s1_byp ? s1_bdata : sram_q) into the 2-entry FIFO at the end of that cycle.
  - sram_q is sampled only in that cycle; garbage Q from REB=1 cycles is never used.
- Response buffer:
  - 2-entry FIFO with independent pointers; simultaneous push and pop are allowed.
  - resp_valid = count ≠ 0; resp_data = head entry, held stable while resp_valid & !resp_ready.
  - The credit rule guarantees a push never finds the FIFO full. Overflow is a design error (assertion).
- A read issued the cycle after a write to the same address returns the new data, since the macro has already updated.

## Timing
- Reset values, all asserted while reset=1:
  - init_done=0, resp_valid=0, resp_data=0, w_ready=0, r_ready=0.
  - sram_web=1, sram_reb=1; these are gated by reset, so no macro access happens during reset.
  - sram_aa=0, sram_ab=0, sram_d=0.
  - FIFO empty, s1_valid=0.
- Init takes DEPTH cycles after reset deasserts: cycles 0..511 write addresses 0..511, and init_done=1 from cycle 512.
- Read latency: fire at cycle T → sram_q valid at T+1 → resp_valid at T+2 at the earliest.
- Throughput with resp_ready=1: one read per cycle sustained. Writes: one per cycle in IDLE, independent of reads.
- Reset asserted mid-operation: in-flight reads and buffered responses are dropped, the FSM returns to INIT, and the array is re-zeroed.
- Requests during INIT are not accepted. Requesters must hold valid until ready.

## Test plan
- Reset release: sram_web=0 for exactly 512 cycles, sram_aa = 0..511, sram_d=0. init_done rises at cycle 512. Then a read of address 300 → resp_data=0.
- Write addr 5 data 2'b10, read addr 5 next cycle → resp_valid two cycles after the read fire, resp_data=2'b10. sram_reb=1 in every non-read cycle.
- Same-cycle write addr 7 data 2'b11 with read addr 7 (prior content 2'b01) → resp_data=2'b11. A read of addr 7 one cycle later also returns 2'b11.
- Back-pressure: resp_ready=0, issue reads A, B, C → A and B accepted, r_ready=0 for C. Raise resp_ready → A, B, then C delivered in order with correct data, and no response lost or duplicated.
- Streaming: 16 back-to-back reads with resp_ready=1 → r_ready stays 1, 16 consecutive resp_valid cycles, in order.
- Reset pulse with 2 responses buffered → resp_valid=0 immediately, the init sweep restarts at 0, and all addresses read 0 afterwards.
